// File: rtl/cond_logic.sv
// ---------------------------------------------------------------------------
// cond_logic
//
// Condition-evaluation and flag-holding stage that sits directly after the
// ALU. It keeps the architectural {N,Z,C,V} flags and evaluates each
// instruction's 4-bit ARM condition field against them. The decoder's PC,
// register-file and memory write requests are gated so that only
// instructions whose condition passes have side effects.
//
// Build option:
//   COND_LOGIC_CONDEX_REG_EN  defined     -> multicycle datapath. The
//                                           condition result is registered,
//                                           and the NextPC fetch advance is
//                                           honoured.
//   COND_LOGIC_CONDEX_REG_EN  not defined -> single-cycle datapath. CondEx
//                                           is combinational, and NextPC is
//                                           ignored.
//
// Ports:
//   clk       in  1  sole clock, rising edge
//   reset     in  1  synchronous, active-high; clears all state
//   Cond      in  4  instruction condition field (Instr[31:28])
//   ALUFlags  in  4  {N,Z,C,V} from the ALU for the executing instruction
//   FlagW     in  2  flag write request: bit1 -> N,Z ; bit0 -> C,V
//   PCS       in  1  instruction writes the PC
//   NextPC    in  1  unconditional PC advance (multicycle build only)
//   RegW      in  1  register-file write request
//   MemW      in  1  data-memory write request
//   PCWrite   out 1  gated PC write enable
//   RegWrite  out 1  gated register-file write enable
//   MemWrite  out 1  gated data-memory write enable
//   Flags     out 4  stored {N,Z,C,V}
//   CondEx    out 1  condition-pass result (registered in multicycle build)
// ---------------------------------------------------------------------------
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  // ARM condition codes, named so that the decode below reads like the ISA table.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  logic [1:0] flags_nz;
  logic [1:0] flags_cv;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       cond_ex_now;
  logic       next_pc_en;
  cond_e      cond_code;

  assign flag_n    = flags_nz[1];
  assign flag_z    = flags_nz[0];
  assign flag_c    = flags_cv[1];
  assign flag_v    = flags_cv[0];
  assign cond_code = cond_e'(Cond);

  // The condition is evaluated against the stored flags only. A flag update
  // in the same cycle is not seen until the next cycle, so ALUFlags never
  // reaches any output combinationally. The 1111 encoding executes
  // unconditionally rather than trapping.
  always_comb begin
    cond_ex_now = 1'b0;
    case (cond_code)
      COND_EQ: cond_ex_now = flag_z;
      COND_NE: cond_ex_now = ~flag_z;
      COND_CS: cond_ex_now = flag_c;
      COND_CC: cond_ex_now = ~flag_c;
      COND_MI: cond_ex_now = flag_n;
      COND_PL: cond_ex_now = ~flag_n;
      COND_VS: cond_ex_now = flag_v;
      COND_VC: cond_ex_now = ~flag_v;
      COND_HI: cond_ex_now = flag_c & ~flag_z;
      COND_LS: cond_ex_now = ~flag_c | flag_z;
      COND_GE: cond_ex_now = (flag_n == flag_v);
      COND_LT: cond_ex_now = (flag_n != flag_v);
      COND_GT: cond_ex_now = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ex_now = flag_z | (flag_n != flag_v);
      COND_AL: cond_ex_now = 1'b1;
      COND_NV: cond_ex_now = 1'b1;
      default: cond_ex_now = 1'b1;
    endcase
  end

  // The NZ and CV pairs have separate write strobes, so an instruction can
  // update only one pair. A failing condition blocks both updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_nz <= 2'b00;
      flags_cv <= 2'b00;
    end else begin
      if (FlagW[1] & cond_ex_now) begin
        flags_nz <= ALUFlags[3:2];
      end
      if (FlagW[0] & cond_ex_now) begin
        flags_cv <= ALUFlags[1:0];
      end
    end
  end

`ifdef COND_LOGIC_CONDEX_REG_EN
  logic cond_ex_q;

  // The multicycle datapath writes back one cycle after execute. Holding
  // the pass/fail result here lines it up with that writeback state. Reset
  // discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_ex_q <= 1'b0;
    end else begin
      cond_ex_q <= cond_ex_now;
    end
  end

  assign CondEx     = cond_ex_q;
  assign next_pc_en = NextPC;
`else
  logic unused_next_pc;

  // The single-cycle datapath has no separate fetch advance, so NextPC is
  // tied off here and only sinks into an unused net.
  assign unused_next_pc = NextPC;
  assign CondEx         = cond_ex_now;
  assign next_pc_en     = 1'b0;
`endif

  assign PCWrite  = (PCS & CondEx) | next_pc_en;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;
  assign Flags    = {flags_nz, flags_cv};

endmodule

// File: tb/tb_cond_logic.sv
// ---------------------------------------------------------------------------
// tb_cond_logic
//
// Directed bench for cond_logic. Each step drives the inputs shortly after a
// rising edge and pushes the results it expects into a scoreboard. Each entry
// names the cycle in which that result must appear. The scoreboard is drained
// on the falling edge of each cycle, and the bench adapts its expected
// latency to the COND_LOGIC_CONDEX_REG_EN build option.
// ---------------------------------------------------------------------------
module tb_cond_logic;

`ifdef COND_LOGIC_CONDEX_REG_EN
  localparam int LAT = 1;
  localparam bit REG_BUILD = 1'b1;
`else
  localparam int LAT = 0;
  localparam bit REG_BUILD = 1'b0;
`endif

  localparam int SEL_FLAGS  = 0;
  localparam int SEL_REGWR  = 1;
  localparam int SEL_MEMWR  = 2;
  localparam int SEL_PCWR   = 3;
  localparam int SEL_CONDEX = 4;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;

  typedef struct {
    int         due;
    string      tag;
    int         sel;
    logic [3:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int       cyc;
  int       checks;
  int       failures;

  cond_logic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags),
    .CondEx   (CondEx)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition model. It decodes the base test from Cond[3:1] and
  // inverts the result when Cond[0] is set. The 1111 encoding always passes.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b1;
    return base ^ c[0];
  endfunction

  // Returns the DUT output that a scoreboard entry refers to.
  function automatic logic [3:0] observe(input int sel);
    case (sel)
      SEL_FLAGS:  return Flags;
      SEL_REGWR:  return {3'b000, RegWrite};
      SEL_MEMWR:  return {3'b000, MemWrite};
      SEL_PCWR:   return {3'b000, PCWrite};
      default:    return {3'b000, CondEx};
    endcase
  endfunction

  // Drives all inputs for the current cycle.
  task automatic applyStimulus(input logic rst, input logic [3:0] c, input logic [3:0] alu,
                               input logic [1:0] fw, input logic pcs, input logic npc,
                               input logic rw, input logic mw);
    reset = rst; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = pcs; NextPC = npc; RegW = rw; MemW = mw;
  endtask

  // Queues a result that must appear 'delay' cycles from the current cycle.
  task automatic pushExpect(input string tag, input int sel, input logic [3:0] exp, input int delay);
    sb_item_t it;
    it.due = cyc + delay; it.tag = tag; it.sel = sel; it.exp = exp;
    sb.push_back(it);
  endtask

  // Compares every entry that is due in this cycle. An entry whose cycle has
  // already passed counts as a failure.
  task automatic checkOutput();
    int i;
    logic [3:0] obs;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        obs = observe(sb[i].sel);
        checks++;
        assert (obs === sb[i].exp) else begin
          failures++;
          $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", sb[i].tag, obs, sb[i].exp, cyc);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s: never compared, expected=%0h due cycle %0d", sb[i].tag, sb[i].exp, sb[i].due);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  // Samples on the falling edge, then moves on to the next cycle.
  task automatic endCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Loads an arbitrary flag value through an always-passing instruction.
  task automatic loadFlags(input logic [3:0] f);
    applyStimulus(1'b0, 4'hE, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    endCycle();
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;

    // Reset is held for two cycles while the inputs try to write all-ones flags.
    applyStimulus(1'b1, 4'h0, 4'hF, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    cyc = 1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 4'h0, 4'hF, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
      pushExpect("reset_flags",  SEL_FLAGS,  4'h0, 0);
      pushExpect("reset_regwr",  SEL_REGWR,  4'h0, 0);
      pushExpect("reset_memwr",  SEL_MEMWR,  4'h0, 0);
      pushExpect("reset_pcwr",   SEL_PCWR,   4'h0, 0);
      pushExpect("reset_condex", SEL_CONDEX, 4'h0, 0);
      endCycle();
    end

    // Split flag update: first NZ only, then CV only.
    applyStimulus(1'b0, 4'hE, 4'hF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExpect("split_nz", SEL_FLAGS, 4'hC, 1);
    endCycle();
    applyStimulus(1'b0, 4'hE, 4'h1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExpect("split_cv", SEL_FLAGS, 4'hD, 1);
    endCycle();

    // Condition sweep over every stored flag value and every condition code.
    for (int f = 0; f < 16; f++) begin
      applyStimulus(1'b0, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      endCycle();
      pushExpect($sformatf("sweep_flags f=%h", f), SEL_FLAGS, 4'(f), 0);
      for (int c = 0; c < 16; c++) begin
        applyStimulus(1'b0, 4'(c), 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        pushExpect($sformatf("sweep f=%h c=%h", f, c), SEL_REGWR,
                   {3'b000, cond_model(4'(c), 4'(f))}, LAT);
        endCycle();
      end
    end

    // A failing EQ blocks both the flag update and the memory write.
    loadFlags(4'h0);
    applyStimulus(1'b0, 4'h0, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    pushExpect("fail_memwr", SEL_MEMWR, 4'h0, LAT);
    pushExpect("fail_flags", SEL_FLAGS, 4'h0, 1);
    endCycle();
    applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    endCycle();

    // The update and the evaluation happen in the same cycle: EQ is decided
    // on the old Z=1, and the cleared flags show up in the next cycle.
    loadFlags(4'h4);
    applyStimulus(1'b0, 4'h0, 4'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    pushExpect("same_condex", SEL_CONDEX, 4'h1, LAT);
    pushExpect("same_regwr",  SEL_REGWR,  4'h1, LAT);
    pushExpect("same_flags",  SEL_FLAGS,  4'h0, 1);
    endCycle();
    applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    endCycle();

    // Reset arriving mid-instruction discards the pending condition result.
    loadFlags(4'h4);
    applyStimulus(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endCycle();
    applyStimulus(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endCycle();
    applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExpect("midreset_condex", SEL_CONDEX, 4'h0, 0);
    pushExpect("midreset_flags",  SEL_FLAGS,  4'h0, 0);
    endCycle();

    // Fetch advance: the single-cycle build ignores NextPC.
    applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    pushExpect("nextpc_pcwr", SEL_PCWR, {3'b000, REG_BUILD}, 0);
    endCycle();

    // A conditional branch with Z=1: NE blocks the PC write, and EQ allows it.
    loadFlags(4'h4);
    applyStimulus(1'b0, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExpect("branch_ne_pcwr", SEL_PCWR, 4'h0, LAT);
    endCycle();
    applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExpect("branch_eq_pcwr", SEL_PCWR, 4'h1, LAT);
    endCycle();
    applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    endCycle();

    // Drain the scoreboard. Anything still queued after the bound has failed.
    for (int k = 0; k < 4 && sb.size() > 0; k++) begin
      applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      endCycle();
    end
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: never compared, expected=%0h", sb[0].tag, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
